// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I-subset core.
// Sequences the shared datapath over 3-5 cycles per instruction. Outputs are Moore
// except pc_write (branch & zero), alu_cntrl (funct decode) and imm_src (opcode decode).
// Optional feature macro: MC_CTRL_MEM_WAIT_EN adds mem_ready; FETCH, MEMREAD and
// MEMWRITE then hold until memory is ready, with their write strobes gated while holding.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_cntrl,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StIllegal  = 4'd11
  } state_e;

  typedef enum logic [1:0] {AluAdd, AluSub, AluFunc} alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    pc_update;
  logic    branch;
  logic    mem_rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State register; reset wins over every transition, including mid-instruction.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_rdy ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBeq;
          default:         state_d = StIllegal;
        endcase
      end
      // opcode bit 5 separates sw (store) from lw (load).
      StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_rdy ? StMemWb : StMemRead;
      StMemWrite: state_d = mem_rdy ? StFetch : StMemWrite;
      StExecR, StExecI, StJal: state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Moore strobes and mux selects; unlisted strobes 0, unlisted selects 00.
  always_comb begin
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = AluAdd;
    case (state_q)
      StFetch: begin
        ir_write   = mem_rdy;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = mem_rdy;
      end
      StDecode: begin
        // Branch target precompute: oldPC + imm.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = mem_rdy;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = AluFunc;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = AluFunc;
      end
      StAluWb: begin
        reg_write = 1'b1;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = AluSub;
        branch    = 1'b1;
      end
      StIllegal: begin
        illegal_instr = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control: fixed add/sub, or decoded from funct3/funct7 for ALU instructions.
  always_comb begin
    alu_cntrl = 3'b000;
    case (alu_op)
      AluSub:  alu_cntrl = 3'b001;
      AluFunc: begin
        case (funct3)
          // Only R-type (opcode bit 5 set) can subtract; addi ignores funct7.
          3'b000:  alu_cntrl = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_cntrl = 3'b101;
          3'b110:  alu_cntrl = 3'b011;
          3'b111:  alu_cntrl = 3'b010;
          default: alu_cntrl = 3'b000;
        endcase
      end
      default: alu_cntrl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign pc_write = pc_update | (branch & zero);
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions cycle by cycle and
// pushes the expected output bundle; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk;
  logic       srst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_cntrl;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal_instr;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  logic [20:0] exp_v;
  logic [20:0] got_v;

  multicycle_ctrl #(
    .RESET_STATE(4'd0)
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .zero         (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready    (1'b1),
`endif
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_cntrl    (alu_cntrl),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .illegal_instr(illegal_instr),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  // ALU operation an ALU instruction means, by its mnemonic.
  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000; // sub only for R-type
      3'b010:  return 3'b101;                                      // slt
      3'b110:  return 3'b011;                                      // or
      3'b111:  return 3'b010;                                      // and
      default: return 3'b000;
    endcase
  endfunction

  // Expected output bundle for one cycle spent in step st of an instruction.
  function automatic logic [20:0] model(input int st, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7, input logic z);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; sa = 0; sb = 0; alu = 0;
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else if (op == 7'b1101111) imm = 2'b11;
    else                       imm = 2'b00;
    case (st)
      0:  begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin adr = 1; end
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; alu = alu_of(op, f3, f7); end
      7:  begin rw = 1; end
      8:  begin sa = 2'b10; sb = 2'b01; alu = alu_of(op, f3, f7); end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      10: begin sa = 2'b10; alu = 3'b001; pcw = z; end
      11: begin ill = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ill, 4'(st)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction starting in the current (FETCH) cycle. z<0 randomizes zero;
  // rst_at>=0 raises srst in that step and abandons the rest of the instruction.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int z, input int rst_at);
    int seq[$];
    case (op)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 7};
      7'b0010011: seq = '{0, 1, 8, 7};
      7'b1101111: seq = '{0, 1, 9, 7};
      7'b1100011: seq = '{0, 1, 10};
      default:    seq = '{0, 1, 11};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) step();
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
      zero     = (z < 0) ? 1'($urandom) : z[0];
      srst     = (i == rst_at);
      exp_q.push_back(model(seq[i], op, f3, f7, zero));
      if (i == rst_at) return;
    end
  endtask

  // Monitor: compare every cycle the scoreboard holds an expectation for.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_cntrl, imm_src, reg_write, illegal_instr, state};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs exp_state=%0d got=%b required=%b", exp_v[3:0], got_v, exp_v);
      end
    end
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         rst_at;
    srst     = 1'b1;
    opcode   = 7'd0;
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    @(posedge clk);
    step();
    // Directed: lw, sw, sub, addi, beq taken/not taken, illegal, reset during MEMREAD.
    run_instr(7'b0000011, 3'b010, 1'b0, -1, -1); step();
    run_instr(7'b0100011, 3'b010, 1'b0, -1, -1); step();
    run_instr(7'b0110011, 3'b000, 1'b1, -1, -1); step();
    run_instr(7'b0010011, 3'b000, 1'b1, -1, -1); step();
    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);  step();
    run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);  step();
    run_instr(7'b1101111, 3'b000, 1'b0, -1, -1); step();
    run_instr(7'b1111111, 3'b000, 1'b0, -1, -1); step();
    run_instr(7'b0000011, 3'b010, 1'b0, -1, 3);  step();
    run_instr(7'b0110011, 3'b111, 1'b0, -1, -1); step();
    // Randomized instruction stream with occasional mid-instruction resets.
    repeat (250) begin
      case ($urandom_range(0, 7))
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2:       op = 7'b0110011;
        3:       op = 7'b0010011;
        4:       op = 7'b1101111;
        5:       op = 7'b1100011;
        default: op = 7'($urandom);
      endcase
      f3     = 3'($urandom);
      f7     = 1'($urandom);
      rst_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, f3, f7, -1, rst_at);
      step();
    end
    // Let the monitor drain, bounded.
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RISC-V RV32I-subset core.
- Sequences the shared datapath (PC register, unified instruction/data memory, register file, ALU, muxes) over 3-5 cycles per instruction.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Decodes opcode/funct fields from the instruction register and drives every datapath enable and mux select. Flags illegal opcodes.

Parameters:
- RESET_STATE, 4'd0, state entered on srst (FETCH); fixed at 0, kept as a parameter for bench forcing only.

Ports:
- clk  input  1  rising-edge clock
- srst  input  1  synchronous reset, active-high
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pc_write  output  1  PC register load enable
- adr_src  output  1  memory address mux: 0=PC, 1=ALUOut
- mem_write  output  1  data memory WE
- ir_write  output  1  instruction register / oldPC load enable
- result_src  output  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  output  2  SrcA mux: 00=PC, 01=oldPC, 10=RD1
- alu_src_b  output  2  SrcB mux: 00=RD2, 01=imm_ext, 10=constant 4
- alu_cntrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  output  2  extender format: 00 I, 01 S, 10 B, 11 J
- reg_write  output  1  register file WE3
- illegal_instr  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current FSM state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ILLEGAL=11.
- srst sampled high at a rising edge: state <= FETCH. srst overrides all transitions, including mid-instruction; no partial writeback follows reset.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by opcode:
    - 0000011 lw / 0100011 sw -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - other -> ILLEGAL
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB.
  - EXECR / EXECI / JAL -> ALUWB.
  - MEMWB / MEMWRITE / ALUWB / BEQ / ILLEGAL -> FETCH.
  - States 12-15 are unreachable; if entered, go to FETCH with all strobes 0.
- Outputs are Moore (function of state only), except pc_write, alu_cntrl and imm_src. Unlisted strobes are 0; unlisted selects are 00.
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch target precompute).
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, aluop=func.
  - EXECI: alu_src_a=10, alu_src_b=01, aluop=func.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, branch=1.
  - ILLEGAL: illegal_instr=1, no writes.
- pc_write = pc_update | (branch & zero), combinational.
- aluop=func decode by funct3:
  - 000: sub if opcode[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - other: add.
- imm_src decoded combinationally from opcode in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Latency: lw 5 cycles; sw, R, I, jal 4; beq 3; illegal 3.
- Reset values (state=FETCH): ir_write=1, pc_write=1, alu_src_b=10, result_src=10; all other outputs 0; illegal_instr=0.

Optional Feature:
- MC_CTRL_MEM_WAIT_EN: adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
  - While holding: ir_write, pc_write and mem_write are gated to 0.
  - The advancing cycle asserts them exactly once.
- Without the macro: no port; every memory state is one cycle.

Test Plan:
- srst=1 for 2 cycles, then release -> state=0, ir_write=1, pc_write=1; next cycle state=1.
- lw (opcode 0000011) -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; 5 cycles total.
- sw (0100011) -> states 0,1,2,5,0; mem_write=1 only in state 5 with adr_src=1; reg_write never asserted.
- R-type sub (0110011, funct3=000, funct7b5=1) -> alu_cntrl=001 in EXECR; same fields with opcode 0010011 -> alu_cntrl=000 (addi).
- beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- Opcode 1111111 -> ILLEGAL with illegal_instr=1 for one cycle, then FETCH. Separately, srst asserted during MEMREAD -> FETCH next cycle and no reg_write.
